// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch front end.
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clear the two low address bits so the PC always lands on a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~{{(PC_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions between the fetch PC and decode.
// The head is read straight out of the storage registers, so it only moves
// when the read pointer moves or when a write lands in an empty queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  fetch_entry_t        r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;

  logic                w_do_push;
  logic                w_do_pop;

  // A flush overrides both sides; pointers and count return to the origin.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop  & ~i_flush & ~o_empty;

  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // Storage write; entries are cleared on reset so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, reads the combinational instruction memory,
// and feeds decode through a registered queue. Redirects flush everything and
// re-steer the PC; fetch stalls while the PC points past the end of memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH      = 4,
  parameter int              IMEM_BYTES = 1024,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               fetch_oob
);

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = align_pc(RESET_PC);
  // One extra bit so PC+3 near the top of the address space cannot wrap.
  localparam logic [PC_W:0]   IMEM_LIMIT       = (PC_W+1)'(IMEM_BYTES);
  localparam logic [PC_W:0]   LAST_BYTE_OFS    = (PC_W+1)'(3);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_redirect_target;
  logic            w_oob;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  assign w_oob = ({1'b0, r_pc} + LAST_BYTE_OFS) >= IMEM_LIMIT;
  assign w_redirect_target = align_pc(redirect_pc);

  // Pop and push are both suppressed during a redirect; a pop in the same
  // cycle frees a slot, so a full queue can still accept a new entry.
  assign w_pop  = ~redirect_valid & ~w_empty & dec_ready;
  assign w_push = ~redirect_valid & ~w_oob & (~w_full | w_pop);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_instr;

  // Next PC: redirect target wins, otherwise advance one word per push.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = w_redirect_target;
    end else if (w_push) begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC_ALIGNED;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr = r_pc;
  assign fetch_oob = w_oob;
  assign dec_valid = ~w_empty;
  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based model.
module tb_fetch_unit;

  localparam int          DEPTH      = 4;
  localparam int          IMEM_BYTES = 1024;
  localparam logic [63:0] RESET_PC   = 64'h0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        fetch_oob;

  logic [31:0] imem [IMEM_BYTES/4];

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [63:0] m_pc;

  fetch_unit #(
    .DEPTH      (DEPTH),
    .IMEM_BYTES (IMEM_BYTES),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_oob      (fetch_oob)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return a marker.
  assign imem_instr = (imem_addr < 64'(IMEM_BYTES)) ? imem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  function automatic logic model_oob(input logic [63:0] pc);
    return ({1'b0, pc} + 65'd3) >= 65'(IMEM_BYTES);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("dec_pc", dec_pc, mq[0].pc);
      check("dec_instr", 64'(dec_instr), 64'(mq[0].instr));
    end
    check("imem_addr", imem_addr, m_pc);
    check("fetch_oob", 64'(fetch_oob), 64'(model_oob(m_pc)));
  endtask

  // One clock: drive inputs, advance the model, clock, check.
  task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
    logic pop, push;
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    if (rv) begin
      mq.delete();
      m_pc = rpc & ~64'h3;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = !model_oob(m_pc) && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = m_pc;
        e.instr = imem[m_pc[9:2]];
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    mq.delete();
    m_pc = RESET_PC;
    #3;
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_fetch_oob", 64'(fetch_oob), 64'(model_oob(RESET_PC)));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < IMEM_BYTES/4; i++) imem[i] = $urandom;
    for (int i = 0; i < 8; i++) imem[i] = 32'hA0 + 32'(i);

    // Streaming with decode always ready.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check("stream_pc", dec_pc, 64'h8);
    check("stream_instr", 64'(dec_instr), 64'hA2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Decode stalled: queue fills, PC freezes at 16, head held.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    check("stall_pc", imem_addr, 64'h10);
    check("stall_head", dec_pc, 64'h0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Redirect with queue holding 8..20.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
    check("pre_redir_head", dec_pc, 64'h8);
    step(1'b1, 64'h102, 1'b1);
    check("redir_valid", 64'(dec_valid), 64'd0);
    check("redir_pc", imem_addr, 64'h100);
    step(1'b0, '0, 1'b1);
    check("redir_first", dec_pc, 64'h100);

    // Last word of memory, then out of bounds, then back to 0.
    step(1'b1, 64'h3FC, 1'b0);
    step(1'b0, '0, 1'b0);
    check("oob_set", 64'(fetch_oob), 64'd1);
    check("oob_head", dec_pc, 64'h3FC);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    check("oob_drained", 64'(dec_valid), 64'd0);
    step(1'b1, 64'h0, 1'b1);
    check("oob_clear", 64'(fetch_oob), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset mid-stream with a full queue.
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
    check("full_before_rst", 64'(mq.size()), 64'(DEPTH));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(dec_valid), 64'd0);
    check("async_rst_pc", imem_addr, RESET_PC);
    mq.delete();
    m_pc = RESET_PC;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    check("post_rst_first", dec_pc, RESET_PC);

    // Redirect in the same cycle as a pop at full.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 64'h200, 1'b1);
    check("redir_pop_empty", 64'(dec_valid), 64'd0);
    step(1'b0, '0, 1'b0);
    check("redir_pop_head", dec_pc, 64'h200);

    // Back-to-back redirects: the last one steers.
    step(1'b1, 64'h40, 1'b1);
    step(1'b1, 64'h87, 1'b1);
    step(1'b0, '0, 1'b1);
    check("b2b_redir", dec_pc, 64'h84);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [63:0] rpc;
      rv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = {$urandom, $urandom};
        1:       rpc = 64'(IMEM_BYTES) - 64'($urandom_range(0, 12));
        default: rpc = 64'($urandom_range(0, IMEM_BYTES - 1));
      endcase
      step(rv, rpc, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
